regfile_sb: RTL and testbench

- Parametrised successor of the 2-read/1-write integer register file.
- Configurable data width, register count and number of read ports.
- Adds async reset clearing of all registers, optional write-to-read bypass, and a per-register pending (scoreboard) bit for pipelined hazard detection.
- Sits between decode (read/issue) and writeback (write/retire) in the pipelined core.

---
 rtl/regfile_sb_if.sv | 29 ++
 rtl/regfile_sb.sv | 64 ++++++
 tb/tb_regfile_sb.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bundle between decode/writeback (master) and the scoreboarded register file (slave).
// Read selects/data are packed per port: port i at [i*AW +: AW] and [i*XLEN +: XLEN].
interface regfile_sb_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NREAD = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]   rd_sel;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  wr_en;
    logic [AW-1:0]         wr_sel;
    logic [XLEN-1:0]       wr_data;
    logic                  iss_en;
    logic [AW-1:0]         iss_sel;
    logic                  any_pending;

    modport master (
        output rd_sel, wr_en, wr_sel, wr_data, iss_en, iss_sel,
        input  rd_data, rd_busy, any_pending
    );

    modport slave (
        input  rd_sel, wr_en, wr_sel, wr_data, iss_en, iss_sel,
        output rd_data, rd_busy, any_pending
    );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with async clear, optional write-to-read bypass and
// a per-register pending bit used by issue logic for hazard detection.
module regfile_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NREAD  = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    regfile_sb_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);

    // x0 has no storage: arrays start at index 1
    logic [XLEN-1:0]  regs [1:NREGS-1];
    logic [NREGS-1:1] pending;

    // Data and scoreboard update; issue wins over a same-cycle write for pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 1; r < int'(NREGS); r++) begin
                regs[r] <= '0;
            end
            pending <= '0;
        end else begin
            for (int r = 1; r < int'(NREGS); r++) begin
                if (bus.wr_en && (bus.wr_sel == AW'(r))) begin
                    regs[r] <= bus.wr_data;
                end
                if (bus.iss_en && (bus.iss_sel == AW'(r))) begin
                    pending[r] <= 1'b1;
                end else if (bus.wr_en && (bus.wr_sel == AW'(r))) begin
                    pending[r] <= 1'b0;
                end
            end
        end
    end

    assign bus.any_pending = |pending;

    // Combinational read ports; bypass sees the result arriving this cycle
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            for (int r = 1; r < int'(NREGS); r++) begin
                if (bus.rd_sel[i*AW +: AW] == AW'(r)) begin
                    bus.rd_data[i*XLEN +: XLEN] = regs[r];
                    bus.rd_busy[i]              = pending[r];
                end
            end
            if (BYPASS && bus.wr_en && (bus.wr_sel != '0) &&
                (bus.wr_sel == bus.rd_sel[i*AW +: AW])) begin
                bus.rd_data[i*XLEN +: XLEN] = bus.wr_data;
                bus.rd_busy[i]              = 1'b0;
            end
        end
        if (reset) begin
            bus.rd_data = '0;
            bus.rd_busy = '0;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: one bypassing and one non-bypassing instance
// share stimulus and are checked against an array-based reference model.
module tb_regfile_sb;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NREAD = 2;
    localparam int unsigned AW    = $clog2(NREGS);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus ();
    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus_nb ();

    assign bus_nb.rd_sel  = bus.rd_sel;
    assign bus_nb.wr_en   = bus.wr_en;
    assign bus_nb.wr_sel  = bus.wr_sel;
    assign bus_nb.wr_data = bus.wr_data;
    assign bus_nb.iss_en  = bus.iss_en;
    assign bus_nb.iss_sel = bus.iss_sel;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .bus(bus_nb)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: architectural values and outstanding producers
    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_pend [NREGS];

    function automatic void model_clear();
        for (int r = 0; r < int'(NREGS); r++) begin
            m_reg[r]  = '0;
            m_pend[r] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        int ws = int'(bus.wr_sel);
        int is = int'(bus.iss_sel);
        if (reset) return;
        if (bus.wr_en && ws != 0) begin
            m_reg[ws]  = bus.wr_data;
            m_pend[ws] = 1'b0;
        end
        if (bus.iss_en && is != 0) m_pend[is] = 1'b1;
    endfunction

    function automatic void exp_rd(input int s, input bit byp,
                                   output logic [XLEN-1:0] d, output logic b);
        if (reset || s == 0) begin
            d = '0; b = 1'b0;
        end else if (byp && bus.wr_en && int'(bus.wr_sel) == s) begin
            d = bus.wr_data; b = 1'b0;
        end else begin
            d = m_reg[s]; b = m_pend[s];
        end
    endfunction

    function automatic logic exp_any();
        logic a = 1'b0;
        if (reset) return 1'b0;
        for (int r = 1; r < int'(NREGS); r++) a |= m_pend[r];
        return a;
    endfunction

    function automatic int sel_of(input int p);
        logic [NREAD*AW-1:0] v = bus.rd_sel;
        return int'(v[p*AW +: AW]);
    endfunction

    task automatic set_rd(input int p, input int s);
        bus.rd_sel[p*AW +: AW] = AW'(s);
    endtask

    task automatic idle();
        bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_data = '0;
        bus.iss_en = 1'b0; bus.iss_sel = '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        logic [XLEN-1:0] d;
        logic            b;
        idle();
        bus.rd_sel = '0;
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        for (int s = 0; s < int'(NREGS); s++) begin
            for (int p = 0; p < int'(NREAD); p++) set_rd(p, s);
            #1;
            for (int p = 0; p < int'(NREAD); p++) begin
                d = bus.rd_data[p*XLEN +: XLEN];
                b = bus.rd_busy[p];
                n_total++;
                if (d !== '0 || b !== 1'b0 || bus.any_pending !== 1'b0)
                    $display("FAIL reset_read x%0d port%0d: data=%h busy=%b any=%b, want 0/0/0",
                             s, p, d, b, bus.any_pending);
                else n_pass++;
            end
        end
    endtask

    task automatic test_write();
        bus.wr_en = 1'b1; bus.wr_sel = AW'(5); bus.wr_data = 32'hDEADBEEF;
        step();
        idle();
        set_rd(0, 5); set_rd(1, 0);
        #1;
        n_total++;
        if (bus.rd_data[0 +: XLEN] !== 32'hDEADBEEF || bus.rd_data[XLEN +: XLEN] !== 32'h0)
            $display("FAIL write_x5: port0=%h port1=%h, want deadbeef/00000000",
                     bus.rd_data[0 +: XLEN], bus.rd_data[XLEN +: XLEN]);
        else n_pass++;
        bus.wr_en = 1'b1; bus.wr_sel = '0; bus.wr_data = 32'h1234;
        step();
        idle();
        set_rd(0, 0);
        #1;
        n_total++;
        if (bus.rd_data[0 +: XLEN] !== 32'h0 || bus_nb.rd_data[0 +: XLEN] !== 32'h0)
            $display("FAIL write_x0: byp=%h nobyp=%h, want 0",
                     bus.rd_data[0 +: XLEN], bus_nb.rd_data[0 +: XLEN]);
        else n_pass++;
    endtask

    task automatic test_bypass();
        bus.wr_en = 1'b1; bus.wr_sel = AW'(7); bus.wr_data = 32'h11111111;
        step();
        bus.wr_data = 32'hA5A5A5A5;
        set_rd(1, 7); set_rd(0, 5);
        #1;
        n_total++;
        if (bus.rd_data[XLEN +: XLEN] !== 32'hA5A5A5A5 || bus.rd_busy[1] !== 1'b0)
            $display("FAIL bypass_on: data=%h busy=%b, want a5a5a5a5/0",
                     bus.rd_data[XLEN +: XLEN], bus.rd_busy[1]);
        else n_pass++;
        n_total++;
        if (bus_nb.rd_data[XLEN +: XLEN] !== 32'h11111111)
            $display("FAIL bypass_off: data=%h, want 11111111", bus_nb.rd_data[XLEN +: XLEN]);
        else n_pass++;
        step();
        idle();
        #1;
        n_total++;
        if (bus_nb.rd_data[XLEN +: XLEN] !== 32'hA5A5A5A5 || bus.rd_data[XLEN +: XLEN] !== 32'hA5A5A5A5)
            $display("FAIL bypass_next: byp=%h nobyp=%h, want a5a5a5a5",
                     bus.rd_data[XLEN +: XLEN], bus_nb.rd_data[XLEN +: XLEN]);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        bus.iss_en = 1'b1; bus.iss_sel = AW'(3);
        set_rd(0, 3);
        #1;
        n_total++;
        if (bus.rd_busy[0] !== 1'b0)
            $display("FAIL issue_same_cycle: busy=%b, want 0", bus.rd_busy[0]);
        else n_pass++;
        step();
        idle();
        #1;
        n_total++;
        if (bus.rd_busy[0] !== 1'b1 || bus.any_pending !== 1'b1 || bus_nb.rd_busy[0] !== 1'b1)
            $display("FAIL issue_busy: busy=%b any=%b nb_busy=%b, want 1/1/1",
                     bus.rd_busy[0], bus.any_pending, bus_nb.rd_busy[0]);
        else n_pass++;
        bus.wr_en = 1'b1; bus.wr_sel = AW'(3); bus.wr_data = 32'h42;
        #1;
        n_total++;
        if (bus.rd_busy[0] !== 1'b0 || bus.rd_data[0 +: XLEN] !== 32'h42 || bus_nb.rd_busy[0] !== 1'b1)
            $display("FAIL retire_bypass: busy=%b data=%h nb_busy=%b, want 0/00000042/1",
                     bus.rd_busy[0], bus.rd_data[0 +: XLEN], bus_nb.rd_busy[0]);
        else n_pass++;
        step();
        idle();
        #1;
        n_total++;
        if (bus.rd_busy[0] !== 1'b0 || bus.any_pending !== 1'b0 || bus_nb.rd_data[0 +: XLEN] !== 32'h42)
            $display("FAIL retire_clear: busy=%b any=%b data=%h, want 0/0/00000042",
                     bus.rd_busy[0], bus.any_pending, bus_nb.rd_data[0 +: XLEN]);
        else n_pass++;
    endtask

    task automatic test_issue_priority();
        bus.iss_en = 1'b1; bus.iss_sel = AW'(3);
        bus.wr_en = 1'b1; bus.wr_sel = AW'(3); bus.wr_data = 32'h99;
        step();
        idle();
        set_rd(0, 3);
        #1;
        n_total++;
        if (bus.rd_data[0 +: XLEN] !== 32'h99 || bus.rd_busy[0] !== 1'b1 || bus.any_pending !== 1'b1)
            $display("FAIL issue_priority: data=%h busy=%b any=%b, want 00000099/1/1",
                     bus.rd_data[0 +: XLEN], bus.rd_busy[0], bus.any_pending);
        else n_pass++;
        bus.wr_en = 1'b1; bus.wr_sel = AW'(3); bus.wr_data = 32'h99;
        step();
        idle();
        bus.iss_en = 1'b1; bus.iss_sel = '0;
        step();
        idle();
        #1;
        n_total++;
        if (bus.any_pending !== 1'b0 || bus.rd_busy[0] !== 1'b0)
            $display("FAIL issue_x0: any=%b busy=%b, want 0/0", bus.any_pending, bus.rd_busy[0]);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bus.iss_en = 1'b1; bus.iss_sel = AW'(1);
        step();
        bus.iss_sel = AW'(2);
        step();
        idle();
        bus.wr_en = 1'b1; bus.wr_sel = AW'(4); bus.wr_data = 32'hFF;
        step();
        idle();
        set_rd(0, 4); set_rd(1, 1);
        #1;
        n_total++;
        if (bus.rd_data[0 +: XLEN] !== 32'hFF || bus.rd_busy[1] !== 1'b1 || bus.any_pending !== 1'b1)
            $display("FAIL pre_reset: data=%h busy=%b any=%b, want 000000ff/1/1",
                     bus.rd_data[0 +: XLEN], bus.rd_busy[1], bus.any_pending);
        else n_pass++;
        #1;
        reset = 1'b1;
        model_clear();
        bus.wr_en = 1'b1; bus.wr_sel = AW'(4); bus.wr_data = 32'h77;
        bus.iss_en = 1'b1; bus.iss_sel = AW'(6);
        #1;
        n_total++;
        if (bus.rd_data !== '0 || bus.rd_busy !== '0 || bus.any_pending !== 1'b0 ||
            bus_nb.rd_data !== '0 || bus_nb.any_pending !== 1'b0)
            $display("FAIL async_reset: data=%h busy=%b any=%b nb_data=%h, want all 0",
                     bus.rd_data, bus.rd_busy, bus.any_pending, bus_nb.rd_data);
        else n_pass++;
        @(posedge clk);
        #3;
        reset = 1'b0;
        idle();
        for (int s = 0; s < int'(NREGS); s++) begin
            set_rd(0, s); set_rd(1, (s + 1) % int'(NREGS));
            #1;
            n_total++;
            if (bus.rd_data !== '0 || bus.rd_busy !== '0 || bus.any_pending !== 1'b0 ||
                bus_nb.rd_data !== '0 || bus_nb.rd_busy !== '0)
                $display("FAIL post_reset x%0d: data=%h busy=%b any=%b, want all 0",
                         s, bus.rd_data, bus.rd_busy, bus.any_pending);
            else n_pass++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [XLEN-1:0] d;
        logic            b;
        for (int c = 0; c < 400; c++) begin
            bus.wr_en   = ($urandom_range(0, 99) < 50);
            bus.wr_sel  = AW'($urandom_range(0, 7));
            bus.wr_data = XLEN'($urandom);
            bus.iss_en  = ($urandom_range(0, 99) < 35);
            bus.iss_sel = AW'($urandom_range(0, 7));
            for (int p = 0; p < int'(NREAD); p++) set_rd(p, $urandom_range(0, 8));
            #1;
            for (int p = 0; p < int'(NREAD); p++) begin
                exp_rd(sel_of(p), 1'b1, d, b);
                n_total++;
                if (bus.rd_data[p*XLEN +: XLEN] !== d || bus.rd_busy[p] !== b)
                    $display("FAIL rand_byp c%0d port%0d x%0d: data=%h busy=%b, want %h/%b",
                             c, p, sel_of(p), bus.rd_data[p*XLEN +: XLEN], bus.rd_busy[p], d, b);
                else n_pass++;
                exp_rd(sel_of(p), 1'b0, d, b);
                n_total++;
                if (bus_nb.rd_data[p*XLEN +: XLEN] !== d || bus_nb.rd_busy[p] !== b)
                    $display("FAIL rand_nobyp c%0d port%0d x%0d: data=%h busy=%b, want %h/%b",
                             c, p, sel_of(p), bus_nb.rd_data[p*XLEN +: XLEN], bus_nb.rd_busy[p], d, b);
                else n_pass++;
            end
            n_total++;
            if (bus.any_pending !== exp_any() || bus_nb.any_pending !== exp_any())
                $display("FAIL rand_any c%0d: byp=%b nobyp=%b, want %b",
                         c, bus.any_pending, bus_nb.any_pending, exp_any());
            else n_pass++;
            step();
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        bus.rd_sel = '0;
        model_clear();
        test_reset();
        test_write();
        test_bypass();
        test_scoreboard();
        test_issue_priority();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
